memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Sits directly downstream of the cache block. Takes its instruction-fetch and data
//  requests (iREN/iaddr, dREN/dWEN/daddr/dstore) and serialises them onto one
//  single-ported RAM with variable latency.
//  - Data requests win over fetches.
//  - Returns the same wait/load handshake that the cache layer turns into ihit/dhit.
//  - Flags RAM faults and timeouts.
// PARAMETERS
//  ADDR_W   32  address width (byte address, passed through unmodified)
//  DATA_W   32  data word width
//  TIMEOUT  15  cycles an access may wait for ramready before ERROR (1..255)
// PORTS
//  CLK       in   1       clock, rising edge
//  nRST      in   1       reset, synchronous, active-low
//  iREN      in   1       instruction read request
//  iaddr     in   ADDR_W  instruction address
//  iwait     out  1       0 only in the cycle the fetch completes
//  iload     out  DATA_W  fetched word, valid when iwait=0
//  dREN      in   1       data read request
//  dWEN      in   1       data write request
//  daddr     in   ADDR_W  data address
//  dstore    in   DATA_W  write data
//  dwait     out  1       0 only in the cycle the data access completes
//  dload     out  DATA_W  read word, valid when dwait=0 on a read
//  ramREN    out  1       RAM read strobe
//  ramWEN    out  1       RAM write strobe
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  DATA_W  RAM write data
//  ramload   in   DATA_W  RAM read data, valid with ramready
//  ramready  in   1       RAM access complete, 1-cycle pulse
//  ramerror  in   1       RAM fault, sampled only during an access
//  err       out  1       sticky fault flag
// BEHAVIOUR
//  Reset (nRST=0 at a CLK edge):
//   - state=IDLE, timer=0.
//   - ramREN=ramWEN=0; ramaddr=ramstore=0; iwait=dwait=1; iload=dload=0; err=0.
//   - Reset mid-access abandons the access. RAM strobes are low the next cycle.
//  FSM states: IDLE, DACC, IACC, ERR. All ram* outputs are registered.
//  IDLE:
//   - If dREN|dWEN: latch daddr and dstore; op=write if dWEN else read (dWEN wins
//     if both are high); go to DACC.
//   - Else if iREN: latch iaddr; go to IACC.
//   - Else stay in IDLE. RAM strobes are 0 while in IDLE.
//  DACC/IACC:
//   - Drive the latched address, data and strobe. IACC always reads.
//   - ramready=1 (and ramerror=0) that cycle:
//     - The owner's wait goes to 0 combinationally.
//     - Its load equals ramload (dload for a write is don't-care, driven 0).
//     - Next state is IDLE; strobes drop next cycle.
//   - ramerror=1, or timer reaches TIMEOUT without ramready: go to ERR.
//     No completion is signalled.
//   - Requester inputs are ignored while in DACC/IACC. A request dropped
//     mid-access still completes on the RAM side; the wait/load pulse is still
//     produced.
//   - The timer clears on entry to DACC/IACC and increments each cycle there.
//     It saturates; it does not wrap.
//  ERR:
//   - err=1; iwait=dwait=1; strobes 0. Held until reset.
//  Wait and load outside completion:
//   - The non-owning wait is always 1.
//   - iload/dload are 0 whenever their wait is 1.
//  Throughput and fairness:
//   - Minimum 2 cycles per access: IDLE latch cycle, then a ready in the first
//     ACC cycle.
//   - Back-to-back requests pass through IDLE between accesses.
//   - A continuous data stream starves fetch. This is intended: the datapath
//     stalls fetch during memory ops.
// TESTING
//  1. Fetch: iREN=1 iaddr=0x40, ramready pulses in the 2nd ACC cycle with
//     ramload=0x8C220004 -> ramREN=1 ramaddr=0x40; iwait=0 and iload=0x8C220004
//     for exactly that cycle.
//  2. Simultaneous: iREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> write issued
//     first (ramWEN=1 ramstore=0xDEADBEEF); dwait pulses 0; the fetch follows via IDLE.
//  3. Address stability: change daddr to 0x200 mid-DACC -> ramaddr stays 0x100
//     until completion.
//  4. Timeout: TIMEOUT=15, DACC with ramready never asserted -> err=1 on the 16th
//     ACC cycle; waits stay 1 and strobes stay 0 thereafter until nRST.
//  5. ramerror=1 in the first IACC cycle -> ERR next cycle, err=1, iwait never 0.
//  6. Reset mid-access: nRST=0 during IACC -> next cycle state IDLE, ramREN=0,
//     err=0, iwait=1; a new dREN is then served normally.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises cache-side instruction and data requests onto a
// single-ported, variable-latency RAM. Data requests win over fetches. A RAM
// fault or an access that waits too long parks the block in a sticky error
// state until reset.
//
//   state | meaning
//   IDLE  | no access in flight; latch the next request (data first)
//   DACC  | data access on the RAM, waiting for ramready
//   IACC  | instruction fetch on the RAM, waiting for ramready
//   ERR   | RAM fault or timeout seen; strobes off, waits high, until reset
module memory_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  input  logic              ramerror,
  output logic              err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DACC = 2'd1;
  localparam logic [1:0] IACC = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  // The timer reads 0 in the first access cycle, so leaving on TIMEOUT-1
  // allows exactly TIMEOUT cycles of waiting before ERR is entered.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] timer;
  logic       op_wr;
  logic       in_acc;
  logic       done;
  logic       give_up;

  // Access completion and abort conditions for the current cycle.
  always_comb begin
    in_acc  = (state == DACC) || (state == IACC);
    done    = in_acc && ramready && !ramerror;
    give_up = in_acc && (ramerror || (!ramready && (timer >= TO_LAST)));
  end

  // Sequencer: request latch, registered RAM strobes, timer and error capture.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      timer    <= 8'd0;
      op_wr    <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dREN || dWEN) begin
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
            op_wr    <= dWEN;
            timer    <= 8'd0;
            state    <= DACC;
          end else if (iREN) begin
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
            timer   <= 8'd0;
            state   <= IACC;
          end
        end
        DACC, IACC: begin
          if (give_up) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= ERR;
          end else if (done) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= IDLE;
          end else if (timer != 8'hFF) begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

  // Requester handshake: the owner's wait drops only in its completion cycle.
  always_comb begin
    iwait = !((state == IACC) && done);
    dwait = !((state == DACC) && done);
    iload = ((state == IACC) && done) ? ramload : '0;
    dload = ((state == DACC) && done && !op_wr) ? ramload : '0;
    err   = (state == ERR);
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed stimulus with a response scoreboard. Stimulus
// pushes the expected completion (owner and load word) into a queue; a monitor
// pops it whenever a wait drops and checks the loads are 0 otherwise.
module tb_memory_arbiter;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } resp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ramready, ramerror, err;

  resp_t sb[$];
  int    total  = 0;
  int    passed = 0;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .ramerror(ramerror), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passed++;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sample at the falling edge of the current cycle.
  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic expect_resp(input bit is_d, input logic [31:0] data);
    resp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: pop on every completion, otherwise loads must be 0.
  initial begin
    resp_t e;
    forever begin
      @(negedge CLK);
      if (!iwait || !dwait) begin
        if (!iwait && !dwait) begin
          total++;
          $display("FAIL both_waits_low iwait=%b dwait=%b required one owner", iwait, dwait);
        end else if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_completion iwait=%b dwait=%b required none", iwait, dwait);
        end else begin
          e = sb.pop_front();
          chk("resp_owner_is_d", 64'(!dwait), 64'(e.is_d));
          chk("resp_load", 64'(!dwait ? dload : iload), 64'(e.data));
        end
      end else begin
        chk("loads_zero_when_waiting", {iload, dload}, 64'd0);
      end
    end
  end

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramready = 0; ramerror = 0;
    tick(); tick();
    nRST = 1'b1;
    at_neg();
    chk("reset_strobes", {ramREN, ramWEN}, 0);
    chk("reset_addr_store", {ramaddr, ramstore}, 0);
    chk("reset_waits", {iwait, dwait}, 2'b11);
    chk("reset_err", err, 0);

    // 1. Fetch with ready in the 2nd access cycle.
    tick();
    iREN = 1; iaddr = 32'h40;
    tick();                         // IACC cycle 1
    iREN = 0; iaddr = 32'h0;
    at_neg();
    chk("fetch_ramREN", {ramREN, ramWEN}, 2'b10);
    chk("fetch_ramaddr", ramaddr, 32'h40);
    tick();                         // IACC cycle 2
    ramready = 1; ramload = 32'h8C220004;
    expect_resp(0, 32'h8C220004);
    tick();                         // back in IDLE
    ramready = 0; ramload = 0;
    at_neg();
    chk("fetch_strobes_drop", {ramREN, ramWEN}, 0);

    // 2/3. Simultaneous fetch and write, write first; address held mid-access.
    tick();
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    tick();                         // DACC cycle 1
    dWEN = 0; daddr = 32'h200; dstore = 32'h0;
    at_neg();
    chk("write_strobes", {ramREN, ramWEN}, 2'b01);
    chk("write_ramstore", ramstore, 32'hDEADBEEF);
    chk("write_addr_c1", ramaddr, 32'h100);
    tick();                         // DACC cycle 2
    at_neg();
    chk("write_addr_c2", ramaddr, 32'h100);
    tick();                         // DACC cycle 3, complete
    ramready = 1; ramload = 32'h12345678;
    expect_resp(1, 32'h0);
    tick();                         // IDLE, fetch latched
    ramready = 0; ramload = 0;
    at_neg();
    chk("via_idle_strobes", {ramREN, ramWEN}, 0);
    tick();                         // IACC cycle 1, minimum latency
    iREN = 0;
    ramready = 1; ramload = 32'h11112222;
    expect_resp(0, 32'h11112222);
    at_neg();
    chk("fetch2_addr", ramaddr, 32'h44);
    tick();
    ramready = 0; ramload = 0;

    // Data read, both dREN and dWEN on a second access (write wins).
    dREN = 1; daddr = 32'h300;
    tick();
    dREN = 0;
    ramready = 1; ramload = 32'hCAFEF00D;
    expect_resp(1, 32'hCAFEF00D);
    at_neg();
    chk("read_strobes", {ramREN, ramWEN}, 2'b10);
    tick();
    ramready = 0; ramload = 0;
    dREN = 1; dWEN = 1; daddr = 32'h304; dstore = 32'hA5A5A5A5;
    tick();
    dREN = 0; dWEN = 0;
    at_neg();
    chk("both_ren_wen_write", {ramREN, ramWEN}, 2'b01);
    tick();
    ramready = 1; ramload = 32'hFFFFFFFF;
    expect_resp(1, 32'h0);
    tick();
    ramready = 0; ramload = 0;

    // 5. ramerror in the first IACC cycle.
    iREN = 1; iaddr = 32'h80;
    tick();
    iREN = 0;
    ramerror = 1;
    tick();
    ramerror = 0;
    at_neg();
    chk("rerr_err", err, 1);
    chk("rerr_strobes", {ramREN, ramWEN}, 0);
    chk("rerr_waits", {iwait, dwait}, 2'b11);

    // 6. Reset mid-access, then a read is served normally.
    nRST = 0;
    tick();
    nRST = 1;
    iREN = 1; iaddr = 32'h90;
    tick();                         // IACC
    iREN = 0;
    nRST = 0;
    tick();
    nRST = 1;
    at_neg();
    chk("midrst_state", {ramREN, err, iwait}, 3'b001);
    dREN = 1; daddr = 32'h500;
    tick();
    dREN = 0;
    ramready = 1; ramload = 32'h5A5A5A5A;
    expect_resp(1, 32'h5A5A5A5A);
    at_neg();
    chk("post_rst_addr", ramaddr, 32'h500);
    tick();
    ramready = 0; ramload = 0;

    // 4. Timeout: 15 waiting cycles, ERR on the 16th.
    dREN = 1; daddr = 32'h600;
    tick();
    dREN = 0;
    for (int k = 1; k <= 15; k++) begin
      at_neg();
      chk($sformatf("to_wait_c%0d", k), {err, ramREN}, 2'b01);
      tick();
    end
    at_neg();
    chk("to_err_c16", {err, ramREN, ramWEN}, 3'b100);
    for (int k = 0; k < 4; k++) begin
      tick();
      ramready = (k == 1);
      iREN = 1; dREN = 1;
      at_neg();
      chk("err_hold", {err, ramREN, ramWEN, iwait, dwait}, 5'b10011);
    end
    iREN = 0; dREN = 0; ramready = 0;
    nRST = 0;
    tick();
    nRST = 1;
    at_neg();
    chk("err_cleared", {err, ramREN, ramWEN, ramaddr, ramstore}, 0);

    tick(); tick();
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
